mem_reader_tx: RTL and testbench
================================

MEM_READER_TX -- requirements
Module: mem_reader_tx

Interface
REQ-001 SHALL have parameter Width, default 8: read-address width.
REQ-002 SHALL have parameter Depth, default 92: number of stored samples per frame (valid range 1..2^Width).
REQ-003 SHALL have parameter DataWidth, default 16: sample width, fixed at 16 (two bytes per sample).
REQ-004 SHALL have port clk_i, input, 1: single clock, all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port start_i, input, 1: frame request; sampled only in IDLE.
REQ-007 SHALL have port rd_addr_o, output, Width: sample memory read address.
REQ-008 SHALL have port rd_data_i, input, 16: memory read data, valid one clock after rd_addr_o is presented.
REQ-009 SHALL have port tx_data_o, output, 8: byte to UART transmitter.
REQ-010 SHALL have port tx_start_o, output, 1: one-cycle pulse requesting transmission of tx_data_o.
REQ-011 SHALL have port tx_done_i, input, 1: one-cycle pulse from transmitter, byte finished.
REQ-012 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done_o, output, 1: one-cycle pulse at frame end.

Function
REQ-014 SHALL implement the FSM IDLE, READ, LATCH, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, DONE.
REQ-015 IDLE: addr register held at 0; start_i=1 -> READ; otherwise stay.
REQ-016 READ: rd_addr_o = addr; unconditionally -> LATCH next cycle.
REQ-017 LATCH: rd_addr_o still = addr; sample register <= rd_data_i at end of cycle; -> SEND_HI.
REQ-018 SEND_HI: tx_start_o=1, tx_data_o=sample[15:8]; -> WAIT_HI unconditionally.
REQ-019 WAIT_HI: tx_data_o=sample[15:8], tx_start_o=0; tx_done_i=1 -> SEND_LO, else stay.
REQ-020 SEND_LO: tx_start_o=1, tx_data_o=sample[7:0]; -> WAIT_LO.
REQ-021 WAIT_LO: tx_data_o=sample[7:0]; on tx_done_i=1: if addr==Depth-1 -> DONE, else addr<=addr+1 and -> READ.
REQ-022 DONE: done_o=1 for exactly one cycle; addr<=0; -> IDLE.
REQ-023 tx_start_o SHALL be high only in SEND_HI/SEND_LO, hence exactly one cycle per byte, 2*Depth pulses per frame.
REQ-024 tx_done_i SHALL be ignored in all states except WAIT_HI/WAIT_LO (including in SEND states of the same cycle).
REQ-025 start_i SHALL be ignored while busy_o=1; no queuing; start_i held high after DONE starts a new frame immediately from IDLE.
REQ-026 tx_data_o SHALL be 8'h00 and rd_addr_o SHALL equal addr (0) in IDLE and DONE.
REQ-027 addr SHALL never exceed Depth-1; increment is Width-bit, no wrap occurs within a frame.
REQ-028 Byte order SHALL be MSB byte first, then LSB byte, addresses ascending 0..Depth-1.
REQ-029 Minimum per-sample latency with tx_done_i arriving the cycle after tx_start_o: 6 cycles (READ, LATCH, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO).

Reset
REQ-030 rst_i=1 SHALL asynchronously force IDLE, addr=0, sample=16'h0000, rd_addr_o=0, tx_data_o=0, tx_start_o=0, busy_o=0, done_o=0.
REQ-031 Reset mid-frame SHALL abort the frame with no further tx_start_o; next start_i restarts at address 0.
REQ-032 After reset release, the first start_i SHALL be honoured on the first rising edge with rst_i low.

Verification
REQ-033 Memory model word(a)=16'hA500+a, Depth=92, start pulse, tx_done_i 1 cycle after each tx_start_o -> 184 bytes A5,00,A5,01,...,A5,5B; done_o one pulse; busy_o low afterwards.
REQ-034 Single sample 16'hA5C3 at addr 0, Depth=1 -> tx_data_o A5 then C3, two tx_start_o pulses, done_o 1 cycle after second tx_done_i.
REQ-035 tx_done_i delayed 10 cycles per byte -> tx_data_o stable through each WAIT state, no extra tx_start_o pulses.
REQ-036 start_i pulsed during WAIT_LO of addr 5 -> ignored; frame completes normally, exactly one done_o.
REQ-037 rst_i asserted in WAIT_HI of addr 40 -> all outputs 0 immediately (asynchronous); new start_i -> first rd_addr_o=0.
REQ-038 Spurious tx_done_i in IDLE, READ, LATCH, SEND_HI -> no state advance, byte count unchanged.

Source files
------------

// File: rtl/mem_reader_tx.sv
// Streams Depth 16-bit samples from a synchronous-read memory to a byte-wide UART,
// high byte first, one tx_start_o pulse per byte and a done_o pulse at frame end.
module mem_reader_tx #(
  parameter int Width     = 8,
  parameter int Depth     = 92,
  parameter int DataWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic [Width-1:0]     rd_addr_o,
  input  logic [DataWidth-1:0] rd_data_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_start_o,
  input  logic                 tx_done_i,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND_HI,
    S_WAIT_HI,
    S_SEND_LO,
    S_WAIT_LO,
    S_DONE
  } state_t;

  localparam logic [Width-1:0] LastAddr = Width'(Depth - 1);

  state_t               r_state;
  logic [Width-1:0]     r_addr;
  logic [DataWidth-1:0] r_sample;
  logic [7:0]           r_tx_data;
  logic                 r_tx_start;
  logic                 r_busy;
  logic                 r_done;

  // Outputs are registered: each transition loads the values of the state being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_sample   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_addr    <= '0;
          r_tx_data <= '0;
          if (start_i) begin
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_sample   <= rd_data_i;
          r_tx_data  <= rd_data_i[15:8];
          r_tx_start <= 1'b1;
          r_state    <= S_SEND_HI;
        end
        S_SEND_HI: begin
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          r_tx_data <= r_sample[15:8];
          if (tx_done_i) begin
            r_tx_data  <= r_sample[7:0];
            r_tx_start <= 1'b1;
            r_state    <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          r_state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (tx_done_i) begin
            r_tx_data <= '0;
            // Clearing addr on the last sample keeps rd_addr_o at 0 throughout DONE.
            if (r_addr == LastAddr) begin
              r_addr  <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_addr  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_addr  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_addr_o  = r_addr;
  assign tx_data_o  = r_tx_data;
  assign tx_start_o = r_tx_start;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_mem_reader_tx.sv
// Self-checking bench for mem_reader_tx: a Depth=92 instance driven by a UART responder
// and checked against an expected byte stream, plus a Depth=1 instance driven from a table.
module tb_mem_reader_tx;
  localparam int W = 8;
  localparam int D = 92;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i, start_i, tx_done_i;
  logic [W-1:0] rd_addr_o;
  logic [15:0]  rd_data_i;
  logic [7:0]   tx_data_o;
  logic         tx_start_o, busy_o, done_o;

  logic         s1_start_i, s1_tx_done_i;
  logic [W-1:0] s1_rd_addr_o;
  logic [15:0]  s1_rd_data_i;
  logic [7:0]   s1_tx_data_o;
  logic         s1_tx_start_o, s1_busy_o, s1_done_o;

  mem_reader_tx #(.Width(W), .Depth(D), .DataWidth(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  mem_reader_tx #(.Width(W), .Depth(1), .DataWidth(16)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .start_i(s1_start_i),
    .rd_addr_o(s1_rd_addr_o), .rd_data_i(s1_rd_data_i),
    .tx_data_o(s1_tx_data_o), .tx_start_o(s1_tx_start_o), .tx_done_i(s1_tx_done_i),
    .busy_o(s1_busy_o), .done_o(s1_done_o)
  );

  logic [15:0]  mem [0:255];
  logic [W-1:0] prev_addr, s1_prev;
  int           checks = 0;
  int           errors = 0;
  int           pend = 0;
  int           fixed_delay = 1;
  bit           rand_delay = 1'b0;
  bit           resp_en = 1'b1;
  bit           was_wait = 1'b0;
  int           inject_at = -1;
  logic [7:0]   last_byte = 8'h00;
  logic [7:0]   obs [$];
  int           n_done = 0;
  int           busy_cycles = 0;

  typedef struct packed {
    logic       start;
    logic       txd;
    logic       busy;
    logic       ts;
    logic [7:0] data;
    logic       cd;
    logic       done;
  } vec_t;
  vec_t tbl [0:11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: memory model (one-cycle read latency), monitor, UART responder.
  task automatic step();
    @(posedge clk);
    #1;
    rd_data_i    = mem[prev_addr];
    prev_addr    = rd_addr_o;
    s1_rd_data_i = (s1_prev == '0) ? 16'hA5C3 : 16'h0000;
    s1_prev      = s1_rd_addr_o;
    if (busy_o) busy_cycles++;
    if (done_o) n_done++;
    was_wait = (pend > 0);
    if (was_wait) begin
      chk("wait_no_extra_start", 32'(tx_start_o), 32'h0);
      chk("wait_data_stable", 32'(tx_data_o), 32'(last_byte));
    end
    start_i = (inject_at >= 0) && was_wait && (obs.size() == inject_at);
    if (resp_en) begin
      tx_done_i = (pend == 1);
      if (pend > 0) pend--;
    end
    if (tx_start_o) begin
      obs.push_back(tx_data_o);
      last_byte = tx_data_o;
      pend = rand_delay ? int'($urandom_range(10, 1)) : fixed_delay;
    end
  endtask

  task automatic run_frame(input string tag, input int abort_at, output bit aborted);
    int cyc;
    obs.delete();
    n_done      = 0;
    busy_cycles = 0;
    pend        = 0;
    aborted     = 1'b0;
    start_i     = 1'b1;
    step();
    chk({tag, "_first_busy"}, 32'(busy_o), 32'h1);
    chk({tag, "_first_addr"}, 32'(rd_addr_o), 32'h0);
    cyc = 0;
    while (n_done == 0 && cyc < 5000) begin
      step();
      cyc++;
      if (abort_at >= 0 && was_wait && obs.size() == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      step();
      step();
      chk({tag, "_done_count"}, n_done, 1);
      chk({tag, "_busy_after"}, 32'(busy_o), 32'h0);
    end
    $display("frame %s bytes=%0d done=%0d busy_cycles=%0d aborted=%0d",
             tag, obs.size(), n_done, busy_cycles, aborted);
  endtask

  // Expected stream: MSB then LSB of each word, addresses 0..D-1 ascending.
  task automatic check_stream(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_nbytes"}, obs.size(), 2 * D);
    for (int a = 0; a < D; a++) begin
      if (2 * a + 1 < obs.size()) begin
        if (obs[2*a] !== mem[a][15:8]) bad++;
        if (obs[2*a+1] !== mem[a][7:0]) bad++;
      end
    end
    chk({tag, "_bad_bytes"}, bad, 0);
  endtask

  initial begin
    bit ab;
    rst_i        = 1'b1;
    start_i      = 1'b0;
    tx_done_i    = 1'b0;
    rd_data_i    = '0;
    s1_start_i   = 1'b0;
    s1_tx_done_i = 1'b0;
    s1_rd_data_i = '0;
    prev_addr    = '0;
    s1_prev      = '0;
    for (int a = 0; a < 256; a++) mem[a] = 16'hA500 + 16'(a);

    //             start txd  busy ts   data   cd   done
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_tx_start", 32'(tx_start_o), 32'h0);
    chk("rst_tx_data", 32'(tx_data_o), 32'h0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_d1_busy", 32'(s1_busy_o), 32'h0);

    // Reset released and start raised in the same cycle: the first edge must take it.
    rst_i = 1'b0;
    run_frame("ramp", -1, ab);
    check_stream("ramp");
    chk("ramp_busy_cycles", busy_cycles, 6 * D + 1);

    // Spurious tx_done_i while idle.
    resp_en   = 1'b0;
    tx_done_i = 1'b1;
    step();
    step();
    step();
    chk("idle_txdone_busy", 32'(busy_o), 32'h0);
    chk("idle_txdone_bytes", obs.size(), 2 * D);
    tx_done_i = 1'b0;
    resp_en   = 1'b1;

    // Depth=1 instance, cycle by cycle.
    for (int i = 0; i < 12; i++) begin
      s1_start_i   = tbl[i].start;
      s1_tx_done_i = tbl[i].txd;
      step();
      $display("row %0d start=%b txd=%b busy=%b ts=%b data=%h done=%b",
               i, tbl[i].start, tbl[i].txd, s1_busy_o, s1_tx_start_o, s1_tx_data_o, s1_done_o);
      chk($sformatf("d1_row%0d_busy", i), 32'(s1_busy_o), 32'(tbl[i].busy));
      chk($sformatf("d1_row%0d_tx_start", i), 32'(s1_tx_start_o), 32'(tbl[i].ts));
      chk($sformatf("d1_row%0d_done", i), 32'(s1_done_o), 32'(tbl[i].done));
      if (tbl[i].cd) chk($sformatf("d1_row%0d_data", i), 32'(s1_tx_data_o), 32'(tbl[i].data));
    end
    s1_start_i   = 1'b0;
    s1_tx_done_i = 1'b0;

    // Random contents, random responder delay, stray start in WAIT_LO of address 5.
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    rand_delay = 1'b1;
    inject_at  = 12;
    run_frame("rand_inject", -1, ab);
    check_stream("rand_inject");
    inject_at  = -1;
    rand_delay = 1'b0;

    // Slow transmitter: ten-cycle tx_done_i delay on every byte.
    fixed_delay = 10;
    run_frame("slow", -1, ab);
    check_stream("slow");
    fixed_delay = 1;

    // Reset in WAIT_HI of address 40 (81st byte outstanding).
    for (int a = 0; a < 256; a++) mem[a] = 16'hA500 + 16'(a);
    run_frame("abort", 81, ab);
    chk("abort_reached", 32'(ab), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("abort_busy", 32'(busy_o), 32'h0);
    chk("abort_tx_start", 32'(tx_start_o), 32'h0);
    chk("abort_tx_data", 32'(tx_data_o), 32'h0);
    chk("abort_rd_addr", 32'(rd_addr_o), 32'h0);
    chk("abort_done", 32'(done_o), 32'h0);
    pend      = 0;
    tx_done_i = 1'b0;
    step();
    step();
    chk("abort_no_more_bytes", obs.size(), 81);
    rst_i = 1'b0;
    run_frame("restart", -1, ab);
    check_stream("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
